// File: rtl/instruction_fetch_unit.sv
// Fetch stage for the single-cycle RV32 core: owns the PC, fetches over
// a req/ready handshake and holds the word for execute.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic        instr_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [CW-1:0] r_wait_cnt;
    logic [1:0]    r_cause;

    state_t        w_state_nxt;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   w_instr_nxt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic [1:0]    w_cause_nxt;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_next_pc;
    logic [31:0]   w_instr;

    // Next-PC selection; JALR target has bit 0 cleared, adds wrap mod 2^32
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        case (pc_src)
            2'b01:   w_next_pc = branch_target;
            2'b10:   w_next_pc = {jump_target[31:1], 1'b0};
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_wait_cnt_nxt = r_wait_cnt;
        w_cause_nxt    = r_cause;
        unique case (r_state)
            BOOT: begin
                w_state_nxt    = REQ;
                w_wait_cnt_nxt = '0;
            end
            REQ: begin
                if (imem_ready) begin
                    w_instr_nxt    = imem_rdata;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = HOLD;
                end else if (r_wait_cnt == LAST_CNT) begin
                    w_cause_nxt = 2'b10;
                    w_state_nxt = FAULT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    // Faulting target is kept in pc for debug
                    w_pc_nxt = w_next_pc;
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_cause_nxt = 2'b01;
                        w_state_nxt = FAULT;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = FAULT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_wait_cnt <= '0;
            r_cause    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    // Outputs decode from state; instr is NOP whenever not valid
    always_comb begin
        imem_req    = (r_state == REQ);
        instr_valid = (r_state == HOLD);
        fault       = (r_state == FAULT);
        fault_cause = r_cause;
        imem_addr   = r_pc;
        pc          = r_pc;
        pc_plus4    = w_pc_plus4;
        w_instr     = instr_valid ? r_instr : NOP_INSTR;
        instr       = w_instr;
        opcode      = w_instr[6:0];
        funct3      = w_instr[14:12];
        funct7      = w_instr[31:25];
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, wait states,
// branch/jump/wrap, misalign and timeout faults, reset mid-request.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        instr_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .instr_ack     (instr_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .fault         (fault),
        .fault_cause   (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        pc_src        = 2'b00;
        branch_target = '0;
        jump_target   = '0;
        instr_ack     = 1'b0;
        imem_ready    = 1'b0;
        imem_rdata    = '0;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, RST_PC);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'h13);

        // T1: ready tied high, zero-wait fetch
        imem_ready = 1'b1;
        imem_rdata = 32'h00a0_0113;
        rst = 1'b1;
        chk("t1_boot_req", 32'(imem_req), 32'd0);
        step();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, RST_PC);
        chk("t1_nop", instr, NOP);
        chk("t1_valid0", 32'(instr_valid), 32'd0);
        step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", instr, 32'h00a0_0113);
        chk("t1_req0", 32'(imem_req), 32'd0);
        chk("t1_pc4", pc_plus4, 32'h0040_0004);
        step();
        chk("t1_hold", 32'(instr_valid), 32'd1);
        chk("t1_hold_instr", instr, 32'h00a0_0113);

        // T2: sequential ack, 3 wait states, ack ignored in REQ
        instr_ack = 1'b1;
        pc_src = 2'b00;
        step();
        imem_ready = 1'b0;
        chk("t2_addr", imem_addr, 32'h0040_0004);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_wait_req", 32'(imem_req), 32'd1);
            chk("t2_wait_addr", imem_addr, 32'h0040_0004);
        end
        instr_ack = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        chk("t2_valid0", 32'(instr_valid), 32'd0);
        step();
        imem_ready = 1'b0;
        chk("t2_valid", 32'(instr_valid), 32'd1);
        chk("t2_instr", instr, 32'h0050_0093);
        chk("t2_opcode", 32'(opcode), 32'h13);
        chk("t2_funct3", 32'(funct3), 32'd0);
        chk("t2_pc", pc, 32'h0040_0004);

        // T3: branch
        pc_src = 2'b01;
        branch_target = 32'h0040_0020;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        chk("t3_addr", imem_addr, 32'h0040_0020);
        imem_ready = 1'b1;
        imem_rdata = 32'h4020_8033;
        step();
        imem_ready = 1'b0;
        chk("t3_pc", pc, 32'h0040_0020);
        chk("t3_pc4", pc_plus4, 32'h0040_0024);
        chk("t3_opcode", 32'(opcode), 32'h33);
        chk("t3_funct7", 32'(funct7), 32'h20);

        // T4: jump with bit0 cleared
        pc_src = 2'b10;
        jump_target = 32'h0040_0105;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        chk("t4_jaddr", imem_addr, 32'h0040_0104);
        chk("t4_nofault", 32'(fault), 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_8067;
        step();
        imem_ready = 1'b0;
        chk("t4_opcode", 32'(opcode), 32'h67);

        // wrap: branch to top of memory, then +4 wraps to 0
        pc_src = 2'b01;
        branch_target = 32'hFFFF_FFFC;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("wrap_pc4", pc_plus4, 32'h0000_0000);
        pc_src = 2'b11;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_nofault", 32'(fault), 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_8067;
        step();
        imem_ready = 1'b0;

        // misaligned jump target
        pc_src = 2'b10;
        jump_target = 32'h0040_0106;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_cause", 32'(fault_cause), 32'd1);
        chk("t4_pc", pc, 32'h0040_0106);
        chk("t4_req0", 32'(imem_req), 32'd0);
        chk("t4_valid0", 32'(instr_valid), 32'd0);
        chk("t4_nop", instr, NOP);

        // T5: timeout
        rst = 1'b0;
        #1;
        chk("t5_rst_fault", 32'(fault), 32'd0);
        step();
        rst = 1'b1;
        imem_ready = 1'b0;
        pc_src = 2'b00;
        step();
        chk("t5_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 15; i++) step();
        chk("t5_still_req", 32'(imem_req), 32'd1);
        chk("t5_no_fault", 32'(fault), 32'd0);
        step();
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_cause", 32'(fault_cause), 32'd2);
        chk("t5_req0", 32'(imem_req), 32'd0);
        instr_ack = 1'b1;
        imem_ready = 1'b1;
        step();
        step();
        chk("t5_sticky", 32'(fault), 32'd1);
        chk("t5_valid0", 32'(instr_valid), 32'd0);
        chk("t5_pc", pc, RST_PC);
        instr_ack = 1'b0;
        imem_ready = 1'b0;

        // T6: reset asserted mid-REQ with ready pulsing
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        chk("t6_in_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b0;
        #1;
        chk("t6_req0", 32'(imem_req), 32'd0);
        chk("t6_fault0", 32'(fault), 32'd0);
        chk("t6_cause0", 32'(fault_cause), 32'd0);
        step();
        chk("t6_valid0", 32'(instr_valid), 32'd0);
        chk("t6_instr", instr, NOP);
        imem_rdata = 32'h0010_0093;
        rst = 1'b1;
        step();
        chk("t6_refetch", imem_addr, RST_PC);
        chk("t6_req1", 32'(imem_req), 32'd1);
        step();
        chk("t6_valid", 32'(instr_valid), 32'd1);
        chk("t6_word", instr, 32'h0010_0093);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
